// File: rtl/arbitro_rr8.sv
// arbitro_rr8: 8-way round-robin / fixed-priority arbiter with
// registered one-hot grant, encoded index and hold-limit preemption.
module arbitro_rr8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  // "release" is a reserved word, hence the suffix
  input  logic       release_i,
  input  logic       mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [4:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] last_idx_q, last_idx_d;

  logic [2:0] rr_idx;
  logic       rr_hit;
  logic [2:0] cand;
  logic [2:0] fp_idx;
  logic [2:0] win_idx;
  logic       owner_req;

  // Round-robin: first set bit after last_idx, wrapping 7 -> 0
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx_q + 3'(k);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Fixed priority: highest set index wins
  always_comb begin
    fp_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) fp_idx = 3'(i);
    end
  end

  assign win_idx   = mode ? fp_idx : rr_idx;
  assign owner_req = req[gnt_idx_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_idx_d  = last_idx_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = BUSY;
          gnt_d       = 8'b1 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          last_idx_d  = win_idx;
        end else begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      BUSY: begin
        // release beats the hold limit when both hit together
        if (!owner_req || release_i) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_idx_q  <= 3'd7;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_idx_q  <= last_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
